// File: rtl/spi_command_sequencer.sv
// Command sequencer for a register-access SPI engine: queues read/write commands,
// issues them one at a time, and returns one response per command with a timeout.
module spi_command_sequencer #(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned NUMBER_OF_SLAVES = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [NUMBER_OF_SLAVES-1:0] cmd_slave,
  input  logic [7:0]                  cmd_addr,
  input  logic [7:0]                  cmd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [7:0]                  rsp_data,
  output logic                        rsp_error,
  output logic                        rsp_write,
  output logic                        spi_start,
  output logic                        spi_operation,
  output logic [NUMBER_OF_SLAVES-1:0] spi_slave,
  output logic [15:0]                 spi_outgoing_data,
  input  logic                        spi_end_of_transaction,
  input  logic [7:0]                  spi_incoming_data,
  output logic                        busy
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The start cycle counts toward the budget, so the last waiting cycle sees TIMEOUT_CYCLES-2.
  localparam int unsigned TO_LAST = TIMEOUT_CYCLES - 2;

  typedef struct packed {
    logic                        write;
    logic [NUMBER_OF_SLAVES-1:0] slave;
    logic [7:0]                  addr;
    logic [7:0]                  data;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_EOT,
    RESPOND,
    GAP
  } state_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  state_t           state;
  logic [TO_W-1:0]  timeout_cnt;
  logic             push_c;
  logic             pop_c;
  logic             busy_nxt;
  cmd_t             head;

  assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push_c    = cmd_valid && cmd_ready;
  assign pop_c     = (state == IDLE) && (count != '0) && !rsp_valid;
  assign head      = fifo_mem[rd_ptr];

  // Next occupancy and busy, so busy can be registered yet track state/count exactly.
  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_nxt = count - CNT_W'(1);
    end
    busy_nxt = (count_nxt != '0) || pop_c || ((state != IDLE) && (state != GAP));
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= cmd_t'({cmd_write, cmd_slave, cmd_addr, cmd_data});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  // Transaction FSM; every engine and response output is a register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      timeout_cnt       <= '0;
      spi_start         <= 1'b0;
      spi_operation     <= 1'b0;
      spi_slave         <= '0;
      spi_outgoing_data <= '0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      rsp_error         <= 1'b0;
      rsp_write         <= 1'b0;
      busy              <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      busy      <= busy_nxt;
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop_c) begin
            spi_operation     <= head.write;
            spi_slave         <= head.slave;
            spi_outgoing_data <= {head.addr, head.write ? head.data : 8'h00};
            spi_start         <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          timeout_cnt <= '0;
          state       <= WAIT_EOT;
        end
        WAIT_EOT: begin
          if (spi_end_of_transaction) begin
            rsp_data  <= spi_operation ? 8'h00 : spi_incoming_data;
            rsp_error <= 1'b0;
            rsp_write <= spi_operation;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end else if (timeout_cnt == TO_W'(TO_LAST)) begin
            rsp_data  <= 8'h00;
            rsp_error <= 1'b1;
            rsp_write <= spi_operation;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end
        RESPOND: begin
          state <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Scoreboard bench for spi_command_sequencer with a small delay-programmable SPI engine model.
module tb_spi_command_sequencer;

  localparam int unsigned FD = 4;
  localparam int unsigned NS = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [NS-1:0] cmd_slave = '0;
  logic [7:0]    cmd_addr = '0;
  logic [7:0]    cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [7:0]    rsp_data;
  logic          rsp_error;
  logic          rsp_write;
  logic          spi_start;
  logic          spi_operation;
  logic [NS-1:0] spi_slave;
  logic [15:0]   spi_outgoing_data;
  logic          spi_end_of_transaction = 1'b0;
  logic [7:0]    spi_incoming_data = '0;
  logic          busy;

  spi_command_sequencer #(
    .FIFO_DEPTH(FD),
    .NUMBER_OF_SLAVES(NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_slave(cmd_slave),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .rsp_write(rsp_write),
    .spi_start(spi_start),
    .spi_operation(spi_operation),
    .spi_slave(spi_slave),
    .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction),
    .spi_incoming_data(spi_incoming_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          op;
    logic [NS-1:0] slave;
    logic [15:0]   out;
  } start_t;

  typedef struct packed {
    logic       write;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  start_t     start_q[$];
  rsp_t       rsp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         start_count = 0;
  int         last_start_cyc = 0;
  int         rsp_rise_cyc = 0;
  int         cyc = 0;
  logic       eng_stall = 1'b0;
  int         eng_delay = 3;
  logic [7:0] eng_rdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Engine model: answers each start after eng_delay cycles unless stalled.
  task automatic engine_loop();
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1 && !eng_stall) begin
        repeat (eng_delay) @(posedge clk);
        #1;
        spi_end_of_transaction = 1'b1;
        spi_incoming_data      = eng_rdata;
        @(posedge clk);
        #1;
        spi_end_of_transaction = 1'b0;
        spi_incoming_data      = 8'h00;
      end
    end
  endtask

  task automatic monitor_loop();
    logic   prev_start;
    logic   prev_valid;
    logic   prev_hs;
    rsp_t   prev_rsp;
    start_t got_s;
    start_t exp_s;
    rsp_t   got_r;
    rsp_t   exp_r;
    prev_start = 1'b0;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_rsp   = '0;
    forever begin
      @(negedge clk);
      got_r = {rsp_write, rsp_data, rsp_error};
      if (spi_start === 1'b1) begin
        start_count++;
        last_start_cyc = cyc;
        got_s = {spi_operation, spi_slave, spi_outgoing_data};
        checks++;
        if (prev_start === 1'b1) begin
          failures++;
          $display("FAIL start_width: spi_start high in consecutive cycles at cycle %0d", cyc);
        end
        checks++;
        if (start_q.size() == 0) begin
          failures++;
          $display("FAIL start_unexpected: got op/slave/out=%h, required no start", got_s);
        end else begin
          exp_s = start_q.pop_front();
          if (got_s !== exp_s) begin
            failures++;
            $display("FAIL start_fields: got op/slave/out=%h required %h", got_s, exp_s);
          end
        end
      end
      if (rsp_valid === 1'b1 && prev_valid !== 1'b1) rsp_rise_cyc = cyc;
      if (rsp_valid === 1'b1 && prev_valid === 1'b1 && !prev_hs) begin
        checks++;
        if (got_r !== prev_rsp) begin
          failures++;
          $display("FAIL rsp_stable: got write/data/err=%h required %h", got_r, prev_rsp);
        end
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        checks++;
        if (rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got write/data/err=%h, required no response", got_r);
        end else begin
          exp_r = rsp_q.pop_front();
          if (got_r !== exp_r) begin
            failures++;
            $display("FAIL rsp_fields: got write/data/err=%h required %h", got_r, exp_r);
          end
        end
      end
      prev_start = spi_start;
      prev_valid = rsp_valid;
      prev_hs    = (rsp_valid === 1'b1) && (rsp_ready === 1'b1);
      prev_rsp   = got_r;
    end
  endtask

  task automatic push_cmd(input logic w, input logic [NS-1:0] s, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rdata, input logic err);
    logic accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_slave = s;
    cmd_addr  = a;
    cmd_data  = d;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        accepted = 1'b1;
        start_q.push_back({w, s, a, w ? d : 8'h00});
        rsp_q.push_back({w, (w || err) ? 8'h00 : exp_rdata, err});
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL push_accept: cmd_ready stayed %b, required 1 within 200 cycles", cmd_ready);
    end
  endtask

  task automatic wait_drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (start_q.size() == 0 && rsp_q.size() == 0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain: %0d starts and %0d responses outstanding, required 0",
               start_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    step(3);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid);
    end
    checks++;
    if ({rsp_data, rsp_error, rsp_write} !== 10'h000) begin
      failures++;
      $display("FAIL reset_rsp_fields: got %h required 000", {rsp_data, rsp_error, rsp_write});
    end
    checks++;
    if ({spi_start, spi_operation, spi_slave, spi_outgoing_data} !== '0) begin
      failures++;
      $display("FAIL reset_spi_fields: got %h required 0",
               {spi_start, spi_operation, spi_slave, spi_outgoing_data});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_write();
    int n0;
    n0        = start_count;
    eng_stall = 1'b0;
    eng_delay = 3;
    push_cmd(1'b1, 2'd1, 8'h12, 8'h34, 8'h00, 1'b0);
    wait_drain(100);
    checks++;
    if (start_count - n0 !== 1) begin
      failures++;
      $display("FAIL write_start_count: got %0d required 1", start_count - n0);
    end
    step(3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL write_idle_busy: got %b required 0", busy);
    end
    step(1);
  endtask

  task automatic test_read();
    eng_rdata = 8'hA5;
    eng_delay = 5;
    push_cmd(1'b0, 2'd0, 8'h80, 8'hFF, 8'hA5, 1'b0);
    wait_drain(100);
  endtask

  task automatic test_full();
    eng_delay = 12;
    eng_rdata = 8'h5C;
    push_cmd(1'b1, 2'd0, 8'h01, 8'h11, 8'h00, 1'b0);
    push_cmd(1'b0, 2'd1, 8'h02, 8'h00, 8'h5C, 1'b0);
    push_cmd(1'b1, 2'd1, 8'h03, 8'h33, 8'h00, 1'b0);
    push_cmd(1'b0, 2'd0, 8'h04, 8'h00, 8'h5C, 1'b0);
    push_cmd(1'b1, 2'd2, 8'h05, 8'h55, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_cmd_ready: got %b required 0", cmd_ready);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL full_busy: got %b required 1", busy);
    end
    @(posedge clk);
    #1;
    push_cmd(1'b1, 2'd3, 8'h06, 8'h66, 8'h00, 1'b0);
    wait_drain(400);
  endtask

  task automatic test_backpressure();
    int   n0;
    logic seen;
    n0        = start_count;
    seen      = 1'b0;
    rsp_ready = 1'b0;
    eng_delay = 2;
    eng_rdata = 8'h3E;
    push_cmd(1'b0, 2'd1, 8'h21, 8'h00, 8'h3E, 1'b0);
    push_cmd(1'b1, 2'd0, 8'h22, 8'h77, 8'h00, 1'b0);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL bp_rsp_valid: rsp_valid got %b, required 1 within 50 cycles", rsp_valid);
    end
    step(20);
    @(negedge clk);
    checks++;
    if (start_count - n0 !== 1) begin
      failures++;
      $display("FAIL bp_held_starts: got %0d starts required 1", start_count - n0);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_error} !== {1'b1, 8'h3E, 1'b0}) begin
      failures++;
      $display("FAIL bp_held_rsp: got valid/data/err=%h required 27c",
               {rsp_valid, rsp_data, rsp_error});
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain(100);
    checks++;
    if (start_count - n0 !== 2) begin
      failures++;
      $display("FAIL bp_release_starts: got %0d starts required 2", start_count - n0);
    end
  endtask

  task automatic test_timeout();
    int n0;
    eng_stall = 1'b1;
    push_cmd(1'b0, 2'd1, 8'h3C, 8'h00, 8'h00, 1'b1);
    wait_drain(100);
    checks++;
    if (rsp_rise_cyc - last_start_cyc !== TO) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles required %0d",
               rsp_rise_cyc - last_start_cyc, TO);
    end
    eng_stall = 1'b0;
    eng_delay = 4;
    n0        = start_count;
    push_cmd(1'b1, 2'd0, 8'h55, 8'hAA, 8'h00, 1'b0);
    wait_drain(100);
    checks++;
    if (start_count - n0 !== 1) begin
      failures++;
      $display("FAIL timeout_next_start: got %0d required 1", start_count - n0);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    eng_stall = 1'b1;
    push_cmd(1'b1, 2'd1, 8'h41, 8'h01, 8'h00, 1'b0);
    push_cmd(1'b1, 2'd1, 8'h42, 8'h02, 8'h00, 1'b0);
    push_cmd(1'b0, 2'd0, 8'h43, 8'h00, 8'h00, 1'b0);
    push_cmd(1'b1, 2'd2, 8'h44, 8'h04, 8'h00, 1'b0);
    step(4);
    reset_n = 1'b0;
    step(1);
    start_q.delete();
    rsp_q.delete();
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL midreset_ctrl: got ready/busy/valid=%b required 100",
               {cmd_ready, busy, rsp_valid});
    end
    checks++;
    if ({spi_start, spi_operation, spi_slave, spi_outgoing_data, rsp_data, rsp_error, rsp_write} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h required 0",
               {spi_start, spi_operation, spi_slave, spi_outgoing_data, rsp_data, rsp_error, rsp_write});
    end
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    eng_stall = 1'b0;
    n0        = start_count;
    step(40);
    @(negedge clk);
    checks++;
    if (start_count - n0 !== 0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: got %0d starts rsp_valid=%b required 0 and 0",
               start_count - n0, rsp_valid);
    end
    @(posedge clk);
    #1;
    eng_delay = 3;
    push_cmd(1'b1, 2'd3, 8'h99, 8'h5A, 8'h00, 1'b0);
    wait_drain(100);
    checks++;
    if (start_count - n0 !== 1) begin
      failures++;
      $display("FAIL midreset_new_start: got %0d required 1", start_count - n0);
    end
  endtask

  initial begin
    fork
      monitor_loop();
      engine_loop();
    join_none
    test_reset();
    test_write();
    test_read();
    test_full();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
